// File: rtl/decode_issue_ctrl.sv
// ID-stage sequencer: holds one instruction, slices it for the immediate generator and
// issues the result to EX over valid/ready, replaying vector opcodes once per SIMD lane.
module decode_issue_ctrl #(
    parameter int LANES = 4,
    parameter int CNT_W = 16,
    localparam int LANE_W = $clog2(LANES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [31:0]       in_instr,
    output logic              in_ready,
    input  logic              stall,
    input  logic              flush,
    output logic [4:0]        igen_opcode,
    output logic [14:0]       igen_p1,
    output logic [9:0]        igen_p2,
    input  logic [31:0]       igen_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4:0]        out_opcode,
    output logic [31:0]       out_imm,
    output logic [LANE_W-1:0] out_lane,
    output logic              out_last,
    output logic [CNT_W-1:0]  issued_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_SCALAR = 2'd1,
        ST_VEC    = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_stateNext;
    logic [29:0]       r_idInstr;
    logic [29:0]       w_idInstrNext;
    logic [LANE_W-1:0] r_laneCnt;
    logic [LANE_W-1:0] w_laneCntNext;

    logic              r_outValid;
    logic [4:0]        r_outOpcode;
    logic [31:0]       r_outImm;
    logic [LANE_W-1:0] r_outLane;
    logic              r_outLast;
    logic [CNT_W-1:0]  r_issuedCnt;

    logic w_idValid;
    logic w_outFree;
    logic w_advance;
    logic w_lastBeat;
    logic w_inReady;
    logic w_accept;
    logic w_unused;

    // Opcode 11000 sits in the vector quadrant but is treated as scalar.
    function automatic logic isVector(input logic [4:0] op);
        return (op[4:3] == 2'b11) && (op != 5'b11000);
    endfunction

    // The two instruction bits below the P2 field carry nothing for this stage.
    assign w_unused = ^in_instr[1:0];

    assign w_idValid  = (r_state != ST_EMPTY);
    assign w_outFree  = !r_outValid || out_ready;
    assign w_advance  = w_idValid && w_outFree && !stall && !flush;
    assign w_lastBeat = (r_state == ST_SCALAR) ||
                        ((r_state == ST_VEC) && (r_laneCnt == LANE_W'(LANES - 1)));
    assign w_inReady  = !flush && (!w_idValid || (w_advance && w_lastBeat));
    assign w_accept   = in_valid && w_inReady;

    assign in_ready    = w_inReady;
    assign igen_opcode = w_idValid ? r_idInstr[29:25] : 5'd0;
    assign igen_p1     = w_idValid ? r_idInstr[24:10] : 15'd0;
    assign igen_p2     = w_idValid ? r_idInstr[9:0]   : 10'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_EMPTY;
            r_idInstr <= '0;
            r_laneCnt <= '0;
        end else begin
            r_state   <= w_stateNext;
            r_idInstr <= w_idInstrNext;
            r_laneCnt <= w_laneCntNext;
        end
    end

    // A same-cycle accept overrides the return to EMPTY after a final beat.
    always_comb begin
        w_stateNext   = r_state;
        w_idInstrNext = r_idInstr;
        w_laneCntNext = r_laneCnt;
        if (flush) begin
            w_stateNext   = ST_EMPTY;
            w_laneCntNext = '0;
        end else begin
            if (w_advance) begin
                if (w_lastBeat) begin
                    w_stateNext   = ST_EMPTY;
                    w_laneCntNext = '0;
                end else begin
                    w_laneCntNext = r_laneCnt + LANE_W'(1);
                end
            end
            if (w_accept) begin
                w_idInstrNext = in_instr[31:2];
                w_laneCntNext = '0;
                w_stateNext   = isVector(in_instr[31:27]) ? ST_VEC : ST_SCALAR;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outValid  <= 1'b0;
            r_outOpcode <= '0;
            r_outImm    <= '0;
            r_outLane   <= '0;
            r_outLast   <= 1'b0;
        end else if (flush) begin
            r_outValid <= 1'b0;
        end else if (w_advance) begin
            r_outValid  <= 1'b1;
            r_outOpcode <= r_idInstr[29:25];
            r_outImm    <= igen_imm;
            r_outLane   <= (r_state == ST_VEC) ? r_laneCnt : '0;
            r_outLast   <= w_lastBeat;
        end else if (out_ready && r_outValid) begin
            r_outValid <= 1'b0;
        end
    end

    // Counted when the final beat enters ID/EX; a later flush does not undo it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_issuedCnt <= '0;
        end else if (w_advance && w_lastBeat) begin
            r_issuedCnt <= r_issuedCnt + CNT_W'(1);
        end
    end

    assign out_valid  = r_outValid;
    assign out_opcode = r_outOpcode;
    assign out_imm    = r_outImm;
    assign out_lane   = r_outLane;
    assign out_last   = r_outLast;
    assign issued_cnt = r_issuedCnt;

endmodule
